// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver configuration hand-off FSM, receive byte FIFO and saturating event counters.
module uart_rx_ctrl #(
  parameter int DEPTH     = 4,
  parameter int PRESC_MIN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_prescale,
  input  logic       cfg_par_en,
  input  logic       cfg_par_typ,
  output logic       cfg_err,
  output logic [5:0] prescale,
  output logic       PAR_EN,
  output logic       PAR_TYP,
  output logic       rx_en,
  input  logic       rx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  input  logic       rx_par_err,
  input  logic       rx_stp_err,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       clr_cnt,
  output logic [7:0] ovf_cnt,
  output logic [7:0] par_err_cnt,
  output logic [7:0] stp_err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [5:0] PMIN = 6'(PRESC_MIN);
  typedef enum logic [1:0] {RUN, DRAIN, APPLY, SETTLE} state_t;
  state_t        r_state;
  logic          r_settle;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          r_dv_q, r_pe_q, r_se_q;
  logic          w_push, w_pop, w_full, w_wr, w_ovf, w_ok;
  function automatic logic [7:0] f_next(input logic [7:0] c, input logic inc, input logic clr);
    return clr ? 8'd0 : c + {7'd0, inc && c != 8'hFF};
  endfunction
  always_comb begin
    w_push = rx_data_valid & ~r_dv_q;
    w_pop  = (r_cnt != '0) & out_ready;
    w_full = r_cnt == (AW+1)'(DEPTH);
    w_wr   = w_push & (~w_full | w_pop);
    w_ovf  = w_push & w_full & ~w_pop;
    w_ok   = cfg_prescale >= PMIN;
  end
  assign out_valid = r_cnt != '0;
  assign out_data  = out_valid ? r_mem[r_rp] : 8'd0;
  // Receiver stays disabled from DRAIN through both SETTLE cycles so it restarts on clean settings
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= RUN;
      r_settle  <= 1'b0;
      rx_en     <= 1'b1;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      prescale  <= 6'd8;
      PAR_EN    <= 1'b1;
      PAR_TYP   <= 1'b0;
    end else begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      case (r_state)
        RUN: if (cfg_valid) begin
          r_state <= DRAIN;
          rx_en   <= 1'b0;
        end
        DRAIN: if (!cfg_valid) begin
          r_state <= RUN;
          rx_en   <= 1'b1;
        end else if (!rx_busy) begin
          r_state   <= APPLY;
          cfg_ready <= 1'b1;
          cfg_err   <= ~w_ok;
        end
        APPLY: begin
          r_state  <= SETTLE;
          r_settle <= 1'b0;
          if (w_ok) begin
            prescale <= cfg_prescale;
            PAR_EN   <= cfg_par_en;
            PAR_TYP  <= cfg_par_typ;
          end
        end
        default: begin
          r_settle <= 1'b1;
          if (r_settle) begin
            r_state <= RUN;
            rx_en   <= 1'b1;
          end
        end
      endcase
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= rx_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_dv_q      <= 1'b0;
      r_pe_q      <= 1'b0;
      r_se_q      <= 1'b0;
      ovf_cnt     <= 8'd0;
      par_err_cnt <= 8'd0;
      stp_err_cnt <= 8'd0;
    end else begin
      r_dv_q      <= rx_data_valid;
      r_pe_q      <= rx_par_err;
      r_se_q      <= rx_stp_err;
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt       <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      ovf_cnt     <= f_next(ovf_cnt, w_ovf, clr_cnt);
      par_err_cnt <= f_next(par_err_cnt, rx_par_err & ~r_pe_q, clr_cnt);
      stp_err_cnt <= f_next(stp_err_cnt, rx_stp_err & ~r_se_q, clr_cnt);
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed config hand-off checks plus randomized FIFO/counter traffic against a queue model.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;
  logic       clk = 1'b0, rst = 1'b0;
  logic       cfg_valid = 1'b0, cfg_par_en = 1'b0, cfg_par_typ = 1'b0, rx_busy = 1'b0;
  logic [5:0] cfg_prescale = 6'd0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_data_valid = 1'b0, rx_par_err = 1'b0, rx_stp_err = 1'b0, out_ready = 1'b0, clr_cnt = 1'b0;
  logic       cfg_ready, cfg_err, PAR_EN, PAR_TYP, rx_en, out_valid;
  logic [5:0] prescale;
  logic [7:0] out_data, ovf_cnt, par_err_cnt, stp_err_cnt;
  int         vectors = 0, miscompares = 0;
  byte unsigned q[$];
  int         m_ovf, m_pe, m_se;
  logic       m_dv, m_pq, m_sq;
  always #5 clk = ~clk;
  uart_rx_ctrl #(.DEPTH(DEPTH), .PRESC_MIN(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ),
    .cfg_err(cfg_err), .prescale(prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .rx_en(rx_en), .rx_busy(rx_busy), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .clr_cnt(clr_cnt),
    .ovf_cnt(ovf_cnt), .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int sat(input int c, input bit inc, input bit clr);
    return clr ? 0 : (inc && c < 255) ? c + 1 : c;
  endfunction
  task automatic step();
    bit push, pop, ov;
    logic [7:0] hd;
    push = rx_data_valid && !m_dv;
    pop  = q.size() > 0 && out_ready;
    ov   = 1'b0;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(rx_data);
      else ov = 1'b1;
    end
    m_ovf = sat(m_ovf, ov, clr_cnt);
    m_pe  = sat(m_pe, rx_par_err && !m_pq, clr_cnt);
    m_se  = sat(m_se, rx_stp_err && !m_sq, clr_cnt);
    m_dv = rx_data_valid; m_pq = rx_par_err; m_sq = rx_stp_err;
    @(posedge clk); #1;
    hd = q.size() > 0 ? q[0] : 8'h00;
    chk("out_valid", out_valid, q.size() > 0);
    chk("out_data", out_data, hd);
    chk("ovf_cnt", ovf_cnt, m_ovf);
    chk("par_err_cnt", par_err_cnt, m_pe);
    chk("stp_err_cnt", stp_err_cnt, m_se);
  endtask
  task automatic do_reset();
    cfg_valid = 0; rx_busy = 0; rx_data_valid = 0; rx_par_err = 0; rx_stp_err = 0;
    out_ready = 0; clr_cnt = 0;
    rst = 1;
    q.delete(); m_ovf = 0; m_pe = 0; m_se = 0; m_dv = 0; m_pq = 0; m_sq = 0;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_rx_en", rx_en, 1); chk("rst_cfg_ready", cfg_ready, 0); chk("rst_cfg_err", cfg_err, 0);
    chk("rst_prescale", prescale, 8); chk("rst_par_en", PAR_EN, 1); chk("rst_par_typ", PAR_TYP, 0);
    chk("rst_out_valid", out_valid, 0); chk("rst_out_data", out_data, 0);
    chk("rst_ovf", ovf_cnt, 0); chk("rst_pe", par_err_cnt, 0); chk("rst_se", stp_err_cnt, 0);
  endtask
  initial begin
    int n;
    do_reset();
    cfg_prescale = 16; cfg_par_en = 0; cfg_par_typ = 1; cfg_valid = 1;
    rx_data = 8'h3C; rx_data_valid = 1;
    step(); chk("c1_rx_en", rx_en, 0); chk("c1_ready", cfg_ready, 0); chk("c1_presc", prescale, 8);
    rx_data_valid = 0;
    step(); chk("c2_ready", cfg_ready, 1); chk("c2_err", cfg_err, 0); chk("c2_rx_en", rx_en, 0);
    chk("c2_presc", prescale, 8);
    cfg_valid = 0;
    step(); chk("c3_presc", prescale, 16); chk("c3_par_en", PAR_EN, 0); chk("c3_par_typ", PAR_TYP, 1);
    chk("c3_ready", cfg_ready, 0); chk("c3_rx_en", rx_en, 0);
    step(); chk("c4_rx_en", rx_en, 0);
    step(); chk("c5_rx_en", rx_en, 1);
    out_ready = 1; step(); out_ready = 0;
    cfg_prescale = 9; cfg_valid = 1; rx_busy = 1;
    step(); chk("abort_rx_en", rx_en, 0);
    cfg_valid = 0;
    step(); chk("abort_back", rx_en, 1); chk("abort_presc", prescale, 16); chk("abort_ready", cfg_ready, 0);
    do_reset();
    rx_busy = 1; cfg_prescale = 5; cfg_valid = 1;
    for (int i = 0; i < 10; i++) begin
      step(); chk("busy_rx_en", rx_en, 0); chk("busy_ready", cfg_ready, 0);
    end
    rx_busy = 0;
    step(); chk("bad_ready", cfg_ready, 1); chk("bad_err", cfg_err, 1);
    cfg_valid = 0;
    step(); chk("bad_err_pulse", cfg_err, 0); chk("bad_presc", prescale, 8); chk("bad_par_en", PAR_EN, 1);
    step(); chk("bad_settle", rx_en, 0);
    step(); chk("bad_run", rx_en, 1);
    do_reset();
    cfg_prescale = 20; cfg_valid = 1;
    step(); step(); chk("mid_ready", cfg_ready, 1);
    #2 rst = 1;
    #1 chk("async_presc", prescale, 8); chk("async_rx_en", rx_en, 1); chk("async_ready", cfg_ready, 0);
    do_reset();
    step(); chk("mid_no_load", prescale, 8);
    do_reset();
    rx_data = 8'hA5; rx_data_valid = 1;
    step(); chk("a5_valid", out_valid, 1); chk("a5_data", out_data, 8'hA5);
    step(); step(); rx_data_valid = 0; step();
    out_ready = 1; step(); chk("a5_single", out_valid, 0); out_ready = 0;
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      rx_data = 8'(i); rx_data_valid = 1; step(); rx_data_valid = 0; step();
    end
    chk("six_ovf", ovf_cnt, 2);
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", out_valid, 1); chk("drain_data", out_data, i); step();
    end
    chk("drain_empty", out_valid, 0); out_ready = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'(8'h10 + i); rx_data_valid = 1; step(); rx_data_valid = 0; step();
    end
    rx_data = 8'h99; rx_data_valid = 1; out_ready = 1; step();
    rx_data_valid = 0; out_ready = 0; chk("pp_ovf", ovf_cnt, 0); step();
    n = 0; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) n++;
      step();
    end
    chk("pp_occupancy", n, 4); out_ready = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rx_stp_err = 1; step(); rx_stp_err = 0; step();
    end
    chk("stp_sat", stp_err_cnt, 255);
    rx_stp_err = 1; clr_cnt = 1; step(); chk("clr_wins", stp_err_cnt, 0);
    clr_cnt = 0; rx_stp_err = 0; step(); chk("clr_hold", stp_err_cnt, 0);
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rx_data       = 8'($urandom);
      rx_data_valid = $urandom_range(0, 2) != 0;
      rx_par_err    = $urandom_range(0, 3) == 0;
      rx_stp_err    = 1'($urandom);
      rx_busy       = 1'($urandom);
      out_ready     = $urandom_range(0, 3) == 0;
      clr_cnt       = $urandom_range(0, 199) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the receive-FIFO entry count (power of two, 2..16).
REQ-002 Parameter PRESC_MIN, default 8, SHALL set the smallest legal prescale.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cfg_valid  in  1  config request; held until accepted.
REQ-006 cfg_ready  out  1  config accepted this cycle.
REQ-007 cfg_prescale  in  6; cfg_par_en  in  1; cfg_par_typ  in  1  requested settings.
REQ-008 cfg_err  out  1  one-cycle pulse: request rejected.
REQ-009 prescale  out  6; PAR_EN  out  1; PAR_TYP  out  1  active settings to receiver.
REQ-010 rx_en  out  1  receiver enable.
REQ-011 rx_busy  in  1  receiver not in IDLE.
REQ-012 rx_data  in  8; rx_data_valid  in  1 (level, may last several cycles); rx_par_err  in  1; rx_stp_err  in  1.
REQ-013 out_data  out  8; out_valid  out  1; out_ready  in  1  byte stream, valid/ready.
REQ-014 clr_cnt  in  1  synchronous clear of all counters.
REQ-015 ovf_cnt, par_err_cnt, stp_err_cnt  out  8 each  saturating event counters.

Function
REQ-016 Control FSM states SHALL be RUN, DRAIN, APPLY, SETTLE.
REQ-017 RUN: rx_en=1; cfg_valid=1 -> DRAIN next cycle.
REQ-018 DRAIN: rx_en=0; rx_busy=0 and cfg_valid=1 -> APPLY; cfg_valid=0 -> RUN; otherwise stay.
REQ-019 APPLY (exactly 1 cycle): cfg_ready=1, rx_en=0; if cfg_prescale>=PRESC_MIN, load all three shadows, else shadows unchanged and cfg_err=1; -> SETTLE.
REQ-020 SETTLE: rx_en=0 for exactly 2 cycles, then -> RUN; cfg_valid is ignored in SETTLE.
REQ-021 Config hand-off latency: with rx_busy=0, cfg_valid rising in RUN -> cfg_ready 2 cycles later; new prescale visible the cycle after cfg_ready; rx_en low 4 cycles total.
REQ-022 prescale/PAR_EN/PAR_TYP SHALL change only on the APPLY->SETTLE edge.
REQ-023 Push event = rising edge of rx_data_valid (registered previous value); one push per frame regardless of pulse length.
REQ-024 Push writes rx_data at the tail; pop occurs when out_valid & out_ready.
REQ-025 out_valid = FIFO non-empty; out_data = head entry, 0 when empty.
REQ-026 Full and push without pop: byte dropped, ovf_cnt+1.
REQ-027 Full with simultaneous push and pop: both performed, no overflow.
REQ-028 Empty with simultaneous push: no pop; out_valid asserts the next cycle (1-cycle latency).
REQ-029 par_err_cnt / stp_err_cnt increment on rising edge of rx_par_err / rx_stp_err respectively.
REQ-030 Counters saturate at 255; clr_cnt=1 wins over a same-cycle increment (result 0).
REQ-031 Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
REQ-032 Push/error-edge detection SHALL operate in every state, including DRAIN/APPLY/SETTLE.

Reset
REQ-033 rst=1 forces, asynchronously: state RUN, rx_en=1, cfg_ready=0, cfg_err=0, prescale=8, PAR_EN=1, PAR_TYP=0.
REQ-034 rst=1 empties the FIFO (out_valid=0, out_data=0), zeroes all counters and edge-detect registers.
REQ-035 Reset mid-DRAIN/APPLY/SETTLE aborts the request; no partial shadow update.

Verification
REQ-036 Reset, then cfg_prescale=16, par_en=0, cfg_valid=1, rx_busy=0 -> cfg_ready at cycle 2, prescale=16/PAR_EN=0 at cycle 3, rx_en low cycles 1-4.
REQ-037 rx_busy=1 for 10 cycles during request -> rx_en=0, cfg_ready held off until 1 cycle after rx_busy falls; cfg_prescale=5 -> cfg_err pulse, prescale stays 8.
REQ-038 rx_data_valid held 3 cycles with 0xA5, out_ready=0 -> exactly one entry; out_valid next cycle, out_data=0xA5.
REQ-039 Six frames 0x01..0x06, out_ready=0 -> ovf_cnt=2; drain reads 0x01..0x04 in order.
REQ-040 FIFO full, push and pop in the same cycle -> ovf_cnt unchanged, occupancy stays 4.
REQ-041 300 rx_stp_err rising edges -> stp_err_cnt=255; clr_cnt coincident with an edge -> 0.
